// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read/modify/write, 64-bit counters, trap/mret
// sequencing of mstatus/mepc/mcause/mtval, and interrupt priority resolution.
module csr_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_HPM     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     rd_en_i,
    input  logic                                     wr_en_i,
    input  logic [1:0]                               csr_op_i,
    input  logic [11:0]                              csr_idx_i,
    input  logic [XLEN-1:0]                          csr_wdata_i,
    output logic [XLEN-1:0]                          csr_rdata_o,
    output logic                                     csr_illegal_o,
    input  logic                                     instr_retire_i,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
    input  logic                                     irq_ext_i,
    input  logic                                     irq_timer_i,
    input  logic                                     irq_sw_i,
    input  logic                                     trap_active_i,
    input  logic [XLEN-1:0]                          trap_cause_i,
    input  logic [XLEN-1:0]                          trap_mepc_i,
    input  logic [XLEN-1:0]                          trap_tval_i,
    input  logic                                     mret_i,
    output logic                                     irq_req_o,
    output logic [XLEN-1:0]                          irq_cause_o,
    output logic [XLEN-1:0]                          trap_vector_o,
    output logic [XLEN-1:0]                          mepc_o
);
    localparam int unsigned HW           = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] MISA_VAL     = 32'h4000_1104;
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] INH_MASK     = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d, minh_q, minh_d;
    logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [2:0]  mip_q;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [31:0]          rval, wval, mip_rd, pend, hpm_rval;
    logic [31:0]          hpm_rd [HW];
    logic [HW-1:0]        hpm_hit;
    logic                 impl, csr_we;
    logic [4:0]           irq_code;

    assign mip_rd = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};

    // One 64-bit event counter per HPM slot; only slots below NUM_HPM decode.
    for (genvar g = 0; g < HW; g++) begin : g_hpm
        logic [63:0] cnt_q, cnt_d;
        logic        inc;
        assign hpm_hit[g] = (NUM_HPM > g) && (csr_idx_i[11:8] == 4'hB) &&
                            (csr_idx_i[6:0] == 7'(g + 3));
        assign inc        = hpm_event_i[g] & ~minh_q[g + 3];
        assign hpm_rd[g]  = csr_idx_i[7] ? cnt_q[63:32] : cnt_q[31:0];
        always_comb begin
            cnt_d = cnt_q + {63'b0, inc};
            if (csr_we && hpm_hit[g]) begin
                cnt_d = csr_idx_i[7] ? {wval, cnt_q[31:0]} : {cnt_q[63:32], wval};
            end
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) cnt_q <= '0;
            else         cnt_q <= cnt_d;
        end
    end

    always_comb begin
        hpm_rval = '0;
        for (int i = 0; i < HW; i++) begin
            if (hpm_hit[i]) hpm_rval = hpm_rd[i];
        end
    end

    always_comb begin
        rval = '0;
        impl = 1'b1;
        case (csr_idx_i)
            12'h300: rval = mstatus_q;
            12'h301: rval = MISA_VAL;
            12'h304: rval = mie_q;
            12'h305: rval = mtvec_q;
            12'h320: rval = minh_q;
            12'h340: rval = mscratch_q;
            12'h341: rval = mepc_q;
            12'h342: rval = mcause_q;
            12'h343: rval = mtval_q;
            12'h344: rval = mip_rd;
            12'hB00: rval = mcycle_q[31:0];
            12'hB80: rval = mcycle_q[63:32];
            12'hB02: rval = minstret_q[31:0];
            12'hB82: rval = minstret_q[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF14: rval = '0;
            default: begin
                impl = |hpm_hit;
                rval = hpm_rval;
            end
        endcase
    end

    assign csr_illegal_o = (rd_en_i | wr_en_i) &&
                           (!impl || (wr_en_i && csr_op_i != 2'b00 && csr_idx_i[11:10] == 2'b11));
    assign csr_rdata_o   = csr_illegal_o ? '0 : rval;
    // Trap and mret own the architectural state this cycle; the CSR write is dropped.
    assign csr_we = wr_en_i && (csr_op_i != 2'b00) && !csr_illegal_o && !trap_active_i && !mret_i;

    always_comb begin
        case (csr_op_i)
            2'b01:   wval = csr_wdata_i;
            2'b10:   wval = rval | csr_wdata_i;
            2'b11:   wval = rval & ~csr_wdata_i;
            default: wval = rval;
        endcase
    end

    always_comb begin
        mcycle_d   = mcycle_q + {63'b0, ~minh_q[0]};
        minstret_d = minstret_q + {63'b0, instr_retire_i & ~minh_q[2]};
        if (csr_we && csr_idx_i == 12'hB00) mcycle_d   = {mcycle_q[63:32], wval};
        if (csr_we && csr_idx_i == 12'hB80) mcycle_d   = {wval, mcycle_q[31:0]};
        if (csr_we && csr_idx_i == 12'hB02) minstret_d = {minstret_q[63:32], wval};
        if (csr_we && csr_idx_i == 12'hB82) minstret_d = {wval, minstret_q[31:0]};
    end

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        minh_d     = minh_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap_active_i) begin
            mepc_d    = {trap_mepc_i[31:1], 1'b0};
            mcause_d  = trap_cause_i;
            mtval_d   = trap_tval_i;
            mstatus_d = {19'b0, 2'b11, 3'b0, mstatus_q[3], 7'b0};
        end else if (mret_i) begin
            mstatus_d = {24'b0, 1'b1, 3'b0, mstatus_q[7], 3'b0};
        end else if (csr_we) begin
            case (csr_idx_i)
                12'h300: mstatus_d  = wval & MSTATUS_MASK;
                12'h304: mie_d      = wval & MIE_MASK;
                12'h305: mtvec_d    = {wval[31:2],
                                       (VECTORED_EN && wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
                12'h320: minh_d     = wval & INH_MASK;
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = {wval[31:1], 1'b0};
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            minh_q     <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            minh_q     <= minh_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= {irq_ext_i, irq_timer_i, irq_sw_i};
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Priority external > software > timer.
    assign pend = mip_rd & mie_q;
    always_comb begin
        irq_code = 5'd0;
        if (pend[11])     irq_code = 5'd11;
        else if (pend[3]) irq_code = 5'd3;
        else if (pend[7]) irq_code = 5'd7;
    end

    assign irq_req_o     = mstatus_q[3] & (|pend);
    assign irq_cause_o   = (|pend) ? {1'b1, 26'b0, irq_code} : '0;
    assign trap_vector_o = {mtvec_q[31:2], 2'b00} +
                           ((mtvec_q[1:0] == 2'b01 && trap_cause_i[31]) ?
                            {25'b0, trap_cause_i[4:0], 2'b00} : 32'b0);
    assign mepc_o        = mepc_q;

endmodule
